// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter sharing one APB memory slave between instruction fetch (port 0) and data (port 1).
// Each grant is replayed downstream as SETUP/ACCESS; a watchdog ends stalled ACCESS phases with pslverr.
module apb_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_psel,
  input  logic                s0_penable,
  input  logic                s0_pwrite,
  input  logic [ADDR_W-1:0]   s0_paddr,
  input  logic [DATA_W-1:0]   s0_pwdata,
  input  logic [DATA_W/8-1:0] s0_pstrb,
  output logic [DATA_W-1:0]   s0_prdata,
  output logic                s0_pready,
  output logic                s0_pslverr,
  input  logic                s1_psel,
  input  logic                s1_penable,
  input  logic                s1_pwrite,
  input  logic [ADDR_W-1:0]   s1_paddr,
  input  logic [DATA_W-1:0]   s1_pwdata,
  input  logic [DATA_W/8-1:0] s1_pstrb,
  output logic [DATA_W-1:0]   s1_prdata,
  output logic                s1_pready,
  output logic                s1_pslverr,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pstrb,
  input  logic [DATA_W-1:0]   m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr,
  output logic                grant,
  output logic                busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_grant, w_grant_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_timeout, w_done, w_other_req, w_own_sel;
  logic             w_rsp_vld, w_rsp_err;
  logic [DATA_W-1:0] w_rsp_dat;
  logic             w_unused;

  // Requester penable carries no information the arbiter needs; psel alone marks a pending transfer.
  assign w_unused = s0_penable ^ s1_penable;

  assign w_timeout   = (TIMEOUT != 0) && (r_state == ACCESS) && !m_pready && (r_cnt == CNT_LAST);
  assign w_done      = (r_state == ACCESS) && (m_pready || w_timeout);
  assign w_other_req = r_grant ? s0_psel : s1_psel;
  assign w_own_sel   = r_grant ? s1_psel : s0_psel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (s0_psel || s1_psel) begin
          w_grant_nxt = (s0_psel && s1_psel) ? ~r_last : s1_psel;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = '0;
      end
      ACCESS: begin
        if (w_done) begin
          w_last_nxt = r_grant;
          // The finishing port's psel is stale this cycle, so only the other port can be handed the bus.
          if (w_other_req) begin
            w_grant_nxt = ~r_grant;
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign grant     = r_grant;
  assign m_psel    = busy;
  assign m_penable = (r_state == ACCESS);
  assign m_pwrite  = busy && (r_grant ? s1_pwrite : s0_pwrite);
  assign m_paddr   = !busy ? '0 : (r_grant ? s1_paddr  : s0_paddr);
  assign m_pwdata  = !busy ? '0 : (r_grant ? s1_pwdata : s0_pwdata);
  assign m_pstrb   = !busy ? '0 : (r_grant ? s1_pstrb  : s0_pstrb);

  // A requester that dropped psel mid-transfer gets no response.
  assign w_rsp_vld = w_done && w_own_sel;
  assign w_rsp_dat = w_timeout ? '0 : m_prdata;
  assign w_rsp_err = w_timeout || m_pslverr;

  assign s0_pready  = w_rsp_vld && !r_grant;
  assign s0_pslverr = w_rsp_vld && !r_grant && w_rsp_err;
  assign s0_prdata  = (w_rsp_vld && !r_grant) ? w_rsp_dat : '0;
  assign s1_pready  = w_rsp_vld && r_grant;
  assign s1_pslverr = w_rsp_vld && r_grant && w_rsp_err;
  assign s1_prdata  = (w_rsp_vld && r_grant) ? w_rsp_dat : '0;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Bench for apb_mem_arbiter: directed vector table, multi-cycle corner sequences,
// and random two-requester traffic scored against a transaction-timing model.
module tb_apb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_psel, s0_penable, s0_pwrite, s1_psel, s1_penable, s1_pwrite;
  logic [AW-1:0] s0_paddr, s1_paddr, m_paddr;
  logic [DW-1:0] s0_pwdata, s1_pwdata, m_pwdata;
  logic [SW-1:0] s0_pstrb, s1_pstrb, m_pstrb;
  logic [DW-1:0] s0_prdata, s1_prdata, m_prdata;
  logic          s0_pready, s0_pslverr, s1_pready, s1_pslverr;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic          grant, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite), .s0_paddr(s0_paddr),
    .s0_pwdata(s0_pwdata), .s0_pstrb(s0_pstrb), .s0_prdata(s0_prdata), .s0_pready(s0_pready),
    .s0_pslverr(s0_pslverr),
    .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite), .s1_paddr(s1_paddr),
    .s1_pwdata(s1_pwdata), .s1_pstrb(s1_pstrb), .s1_prdata(s1_prdata), .s1_pready(s1_pready),
    .s1_pslverr(s1_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_prdata(m_prdata), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .grant(grant), .busy(busy)
  );

  // Slave: fixed mode uses fx_* values; auto mode derives waits/data/error from the address.
  logic        sl_fixed;
  int          fx_waits;
  logic [31:0] fx_rdata;
  logic        fx_err;
  int          sl_cnt = 0;
  int          sl_w;

  function automatic int auto_waits(input logic [31:0] a);
    return a[8] ? 40 : int'(a[5:4]);
  endfunction

  function automatic logic [31:0] auto_rdata(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic int dur(input logic [31:0] a);
    return (auto_waits(a) >= TO) ? TO : auto_waits(a) + 1;
  endfunction

  always_comb begin
    sl_w      = sl_fixed ? fx_waits : auto_waits(m_paddr);
    m_pready  = m_psel && m_penable && (sl_cnt == sl_w);
    m_prdata  = (m_psel && m_penable) ? (sl_fixed ? fx_rdata : auto_rdata(m_paddr)) : '0;
    m_pslverr = m_psel && m_penable && (sl_fixed ? fx_err : m_paddr[2]);
  end

  always @(posedge clk) sl_cnt <= (m_psel && m_penable && !m_pready) ? sl_cnt + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic sel, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st);
    if (p == 0) begin
      s0_psel = sel; s0_penable = sel; s0_pwrite = wr; s0_paddr = a; s0_pwdata = d; s0_pstrb = st;
    end else begin
      s1_psel = sel; s1_penable = sel; s1_pwrite = wr; s1_paddr = a; s1_pwdata = d; s1_pstrb = st;
    end
  endtask

  function automatic logic pr_of(input int p);
    return (p == 0) ? s0_pready : s1_pready;
  endfunction
  function automatic logic er_of(input int p);
    return (p == 0) ? s0_pslverr : s1_pslverr;
  endfunction
  function automatic logic [31:0] rd_of(input int p);
    return (p == 0) ? s0_prdata : s1_prdata;
  endfunction

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask
  task automatic at_sample();
    @(negedge clk);
  endtask
  task automatic step();
    at_sample();
    at_drive();
  endtask

  task automatic do_reset();
    at_drive();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    at_drive();
    at_drive();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ctl"}, {m_psel, m_penable, m_pwrite, busy, grant,
                        s0_pready, s0_pslverr, s1_pready, s1_pslverr}, 0);
    chk({tag, " data"}, {31'd0, |{m_paddr, m_pwdata, m_pstrb, s0_prdata, s1_prdata}}, 0);
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    int          exp_done;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Random-phase requester state and model state.
  logic        act[2];
  int          gap[2];
  logic        rw[2];
  logic [31:0] ra[2];
  logic [31:0] rdw[2];
  logic [3:0]  rs[2];
  logic        er[2];
  logic        er_prev[2];

  initial begin
    vec_t vt[6];
    int seen, pulses, other_bad, nc, first, mo, mlast, m_end, nxt;
    logic [31:0] got_d, exp_d;
    logic got_e, exp_e;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    sl_fixed = 1'b1; fx_waits = 0; fx_rdata = 0; fx_err = 1'b0;

    vt[0] = '{0, 1'b0, 32'h10,  32'h0,        4'h0, 0,   32'hDEADBEEF, 1'b0, 2,  32'hDEADBEEF, 1'b0};
    vt[1] = '{1, 1'b1, 32'h100, 32'hA5A5A5A5, 4'h3, 3,   32'h12345678, 1'b0, 5,  32'h12345678, 1'b0};
    vt[2] = '{0, 1'b0, 32'h2C,  32'h0,        4'h0, 15,  32'hCAFEF00D, 1'b0, 17, 32'hCAFEF00D, 1'b0};
    vt[3] = '{1, 1'b0, 32'h30,  32'h0,        4'h0, 16,  32'h55AA55AA, 1'b0, 17, 32'h0,        1'b1};
    vt[4] = '{0, 1'b1, 32'h44,  32'h01020304, 4'hF, 2,   32'h0BADF00D, 1'b1, 4,  32'h0BADF00D, 1'b1};
    vt[5] = '{1, 1'b0, 32'h48,  32'h0,        4'h0, 100, 32'h77777777, 1'b0, 17, 32'h0,        1'b1};

    do_reset();
    at_sample();
    chk_quiet("reset");

    for (int i = 0; i < 6; i++) begin
      sl_fixed = 1'b1; fx_waits = vt[i].waits; fx_rdata = vt[i].rdata; fx_err = vt[i].err;
      at_drive();
      drive(vt[i].port, 1, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb);
      seen = -1; pulses = 0; other_bad = 0; got_d = 0; got_e = 1'b0;
      for (int k = 0; k < 30; k++) begin
        at_sample();
        if (k == 1) begin
          chk($sformatf("v%0d setup ctl", i), {m_psel, m_penable, grant}, {2'b10, 1'(vt[i].port)});
          chk($sformatf("v%0d m_paddr", i), m_paddr, vt[i].addr);
          chk($sformatf("v%0d m_pwdata", i), m_pwdata, vt[i].wdata);
          chk($sformatf("v%0d m_pstrb/pwrite", i), {m_pstrb, m_pwrite}, {vt[i].strb, vt[i].wr});
        end
        if (k == 2) chk($sformatf("v%0d access ctl", i), {m_psel, m_penable}, 2'b11);
        if (pr_of(vt[i].port)) begin
          pulses++;
          if (seen < 0) begin
            seen = k; got_d = rd_of(vt[i].port); got_e = er_of(vt[i].port);
          end
        end
        if (pr_of(1 - vt[i].port) || er_of(1 - vt[i].port) || rd_of(1 - vt[i].port) != 0) other_bad++;
        if (seen >= 0 && k == seen + 1) chk($sformatf("v%0d release", i), {m_psel, m_penable}, 0);
        at_drive();
        if (k == seen) drive(vt[i].port, 0, 0, 0, 0, 0);
      end
      chk($sformatf("v%0d done cycle", i), seen, vt[i].exp_done);
      chk($sformatf("v%0d prdata", i), got_d, vt[i].exp_rdata);
      chk($sformatf("v%0d pslverr", i), got_e, vt[i].exp_err);
      chk($sformatf("v%0d pready pulses", i), pulses, 1);
      chk($sformatf("v%0d idle port quiet", i), other_bad, 0);
    end

    // Both ports requesting continuously from the same cycle: strict alternation, 2 cycles apart.
    do_reset();
    sl_fixed = 1'b1; fx_waits = 0; fx_rdata = 32'h11; fx_err = 1'b0;
    at_drive();
    drive(0, 1, 0, 32'h40, 0, 0);
    drive(1, 1, 0, 32'h80, 0, 0);
    nc = 0; first = 0;
    for (int k = 0; k < 40 && nc < 6; k++) begin
      at_sample();
      if (k == 1) chk("tie first grant", {m_psel, m_penable, grant}, 3'b100);
      if (nc == 1 && k == first + 1) chk("tie handoff setup", {m_psel, m_penable, grant}, 3'b101);
      if (s0_pready || s1_pready) begin
        chk($sformatf("alt%0d port", nc), {s0_pready, s1_pready}, (nc % 2 == 0) ? 2'b10 : 2'b01);
        chk($sformatf("alt%0d cycle", nc), k, 2 + 2 * nc);
        if (nc == 0) first = k;
        nc++;
      end
      at_drive();
    end
    chk("alt count", nc, 6);

    // Port 1 write with 3 wait states; port 0 arrives during ACCESS and is set up right after.
    do_reset();
    sl_fixed = 1'b1; fx_waits = 3; fx_rdata = 32'h0; fx_err = 1'b0;
    at_drive();
    drive(1, 1, 1, 32'h100, 32'hA5A5A5A5, 4'b0011);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      at_sample();
      if (s1_pready) pulses++;
      if (k == 4) chk("wr stalled", {s1_pready, m_pwdata, m_pstrb}, {1'b0, 32'hA5A5A5A5, 4'b0011});
      if (k == 5) chk("wr done 4th access", s1_pready, 1);
      if (k == 6) chk("p0 setup after wr", {m_psel, m_penable, grant, m_paddr}, {3'b100, 32'h200});
      if (k == 10) chk("p0 done after handoff", s0_pready, 1);
      at_drive();
      if (k == 1) drive(0, 1, 0, 32'h200, 0, 0);
      if (k == 5) drive(1, 0, 0, 0, 0, 0);
      if (k == 10) drive(0, 0, 0, 0, 0, 0);
    end
    chk("wr pready pulses", pulses, 1);

    // Reset in the middle of ACCESS; the tie that follows must go to port 0 again.
    do_reset();
    sl_fixed = 1'b1; fx_waits = 0;
    at_drive();
    drive(0, 1, 0, 32'h20, 0, 0);
    step();
    step();
    at_sample();
    chk("pre-rst p0 done", s0_pready, 1);
    at_drive();
    drive(0, 0, 0, 0, 0, 0);
    fx_waits = 100;
    drive(1, 1, 0, 32'h24, 0, 0);
    step();
    step();
    rst = 1'b1;
    at_sample();
    chk("pre-rst in access", {busy, m_penable, grant, s1_pready}, 4'b1110);
    at_drive();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    fx_waits = 0;
    at_sample();
    chk_quiet("rst mid-access");
    at_drive();
    drive(0, 1, 0, 32'h30, 0, 0);
    drive(1, 1, 0, 32'h34, 0, 0);
    at_drive();
    at_sample();
    chk("post-rst tie grant", {m_psel, m_penable, grant}, 3'b100);

    // Requester drops psel while its transfer is in flight: bus finishes, response suppressed.
    do_reset();
    sl_fixed = 1'b1; fx_waits = 2;
    at_drive();
    drive(0, 1, 0, 32'h44, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int k = 2; k < 8; k++) begin
      at_sample();
      if (s0_pready) pulses++;
      if (k == 4) chk("drop still running", {m_psel, m_penable}, 2'b11);
      if (k == 5) chk("drop finished", busy, 0);
      at_drive();
    end
    chk("dropped response", pulses, 0);

    // Random traffic against the transfer-timing model.
    do_reset();
    sl_fixed = 1'b0;
    mo = -1; mlast = 1; m_end = 0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; gap[p] = p + 1; er_prev[p] = 1'b0;
      rw[p] = 1'b0; ra[p] = 0; rdw[p] = 0; rs[p] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (er_prev[p]) begin
          act[p] = 1'b0;
          gap[p] = int'($urandom_range(0, 3));
        end
        if (!act[p]) begin
          if (gap[p] == 0) begin
            act[p] = 1'b1;
            rw[p]  = 1'($urandom_range(0, 1));
            ra[p]  = $urandom & 32'h0000_FEFC;
            if ($urandom_range(0, 9) == 0) ra[p][8] = 1'b1;
            rdw[p] = $urandom;
            rs[p]  = 4'($urandom_range(0, 15));
          end else begin
            gap[p]--;
          end
        end
        drive(p, act[p], rw[p], ra[p], rdw[p], rs[p]);
      end
      at_sample();
      er[0] = 1'b0; er[1] = 1'b0; exp_d = 0; exp_e = 1'b0;
      chk("rnd busy", busy, (mo >= 0) ? 1 : 0);
      if (mo >= 0) chk("rnd grant", grant, mo);
      nxt = -2;
      if (mo >= 0 && cyc == m_end) begin
        er[mo] = 1'b1;
        exp_d  = (auto_waits(ra[mo]) >= TO) ? 32'h0 : auto_rdata(ra[mo]);
        exp_e  = (auto_waits(ra[mo]) >= TO) || ra[mo][2];
        chk("rnd m_paddr", m_paddr, ra[mo]);
        chk("rnd m_pwdata", m_pwdata, rdw[mo]);
        chk("rnd m_pstrb/pwrite", {m_pstrb, m_pwrite}, {rs[mo], rw[mo]});
        mlast = mo;
        nxt = act[1 - mo] ? 1 - mo : -1;
      end else if (mo < 0) begin
        nxt = (act[0] && act[1]) ? 1 - mlast : (act[0] ? 0 : (act[1] ? 1 : -1));
      end
      chk("rnd pready", {s0_pready, s1_pready}, {er[0], er[1]});
      chk("rnd s0 rsp", {s0_prdata, s0_pslverr}, er[0] ? {exp_d, exp_e} : 33'd0);
      chk("rnd s1 rsp", {s1_prdata, s1_pslverr}, er[1] ? {exp_d, exp_e} : 33'd0);
      if (nxt != -2) begin
        mo = nxt;
        if (nxt >= 0) m_end = cyc + 1 + dur(ra[nxt]);
      end
      er_prev[0] = er[0];
      er_prev[1] = er[1];
      at_drive();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL global time limit: got expired, want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
